// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer for the 5-stage MIPS pipeline.
// Chooses the next PC (sequential, D-stage redirect, exception vector, EPC),
// runs the request/ready handshake with a variable-latency instruction memory,
// buffers a fetched word while D is stalled, and drains an outstanding fetch
// when a redirect or kill arrives before the memory has answered.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] PC_HI      = 32'h0000_6FFC,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    output logic [31:0] npc,
    output logic        pc_stall,
    input  logic        stall_hazard,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_f,
    output logic        instr_valid_f,
    output logic        adel_f
);

    // FETCH: a request is outstanding or may be issued.
    // HOLD : a fetched word sits in hold_buf while D is stalled.
    // DRAIN: a new PC is pending but the memory still owes us a word.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] hold_buf_reg, hold_buf_next;
    logic        pend_valid_reg, pend_valid_next;
    logic        pend_kill_reg, pend_kill_next;
    logic [31:0] pend_target_reg, pend_target_next;

    logic        bad_addr;
    logic        kill;
    logic [31:0] kill_target;
    logic [31:0] seq_pc;
    logic        fetch_req;
    logic        fetch_avail;
    logic        fetch_deliver;

    // Address checks and kill source selection, shared by every state.
    always_comb begin
        bad_addr    = (pc_f[1:0] != 2'b00) || (pc_f < RESET_PC) || (pc_f > PC_HI);
        kill        = exc_req | eret_req;
        kill_target = exc_req ? EXC_VECTOR : epc;
        seq_pc      = pc_f + 32'd4;
        // In FETCH a word is available either from memory or as the nop that
        // stands in for a faulting fetch address.
        fetch_req     = !bad_addr;
        fetch_avail   = bad_addr || imem_ready;
        fetch_deliver = fetch_avail && !stall_hazard;
    end

    // Next-state and output decode; each state decides delivery and PC load.
    always_comb begin
        state_next       = state_reg;
        hold_buf_next    = hold_buf_reg;
        pend_valid_next  = pend_valid_reg;
        pend_kill_next   = pend_kill_reg;
        pend_target_next = pend_target_reg;

        npc           = seq_pc;
        pc_stall      = 1'b1;
        imem_req      = 1'b0;
        imem_addr     = pc_f;
        instr_f       = 32'h0;
        instr_valid_f = 1'b0;
        adel_f        = 1'b0;

        if (reset) begin
            npc      = RESET_PC;
            pc_stall = 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    imem_req = fetch_req;
                    adel_f   = bad_addr;
                    instr_f  = bad_addr ? 32'h0 : imem_rdata;
                    if (kill) begin
                        // F is killed. A request still waiting on memory has to
                        // be drained before the new PC can be loaded.
                        if (fetch_req && !imem_ready) begin
                            pend_valid_next  = 1'b1;
                            pend_kill_next   = 1'b1;
                            pend_target_next = kill_target;
                            state_next       = DRAIN;
                        end else begin
                            npc      = kill_target;
                            pc_stall = 1'b0;
                        end
                    end else if (fetch_deliver) begin
                        // The word in F is delivered; a redirect in the same
                        // cycle treats it as the delay slot and loads the target.
                        instr_valid_f = 1'b1;
                        pc_stall      = 1'b0;
                        npc           = redirect_valid ? redirect_target : seq_pc;
                    end else if (imem_ready && fetch_req) begin
                        // Word arrived while D is stalled: park it.
                        hold_buf_next = imem_rdata;
                        state_next    = HOLD;
                    end else if (redirect_valid && !stall_hazard) begin
                        // Delay slot still in flight: remember the target.
                        pend_valid_next  = 1'b1;
                        pend_kill_next   = 1'b0;
                        pend_target_next = redirect_target;
                        state_next       = DRAIN;
                    end
                end

                HOLD: begin
                    instr_f = hold_buf_reg;
                    if (kill) begin
                        // Nothing outstanding in HOLD, so the kill loads at once.
                        npc             = kill_target;
                        pc_stall        = 1'b0;
                        pend_valid_next = 1'b0;
                        pend_kill_next  = 1'b0;
                        state_next      = FETCH;
                    end else if (!stall_hazard) begin
                        instr_valid_f = 1'b1;
                        pc_stall      = 1'b0;
                        // A redirect parked during DRAIN takes effect on release.
                        if (pend_valid_reg) begin
                            npc = pend_target_reg;
                        end else if (redirect_valid) begin
                            npc = redirect_target;
                        end else begin
                            npc = seq_pc;
                        end
                        pend_valid_next = 1'b0;
                        pend_kill_next  = 1'b0;
                        state_next      = FETCH;
                    end
                end

                DRAIN: begin
                    // Keep the original request alive on the held pc_f.
                    imem_req = 1'b1;
                    instr_f  = imem_rdata;
                    if (kill) begin
                        if (imem_ready) begin
                            npc             = kill_target;
                            pc_stall        = 1'b0;
                            pend_valid_next = 1'b0;
                            pend_kill_next  = 1'b0;
                            state_next      = FETCH;
                        end else begin
                            // The newest kill wins; it is never dropped.
                            pend_kill_next   = 1'b1;
                            pend_target_next = kill_target;
                        end
                    end else if (imem_ready) begin
                        if (pend_kill_reg) begin
                            // Discard the returning word.
                            npc             = pend_target_reg;
                            pc_stall        = 1'b0;
                            pend_valid_next = 1'b0;
                            pend_kill_next  = 1'b0;
                            state_next      = FETCH;
                        end else if (!stall_hazard) begin
                            // Delay slot delivered together with the PC load.
                            instr_valid_f   = 1'b1;
                            npc             = pend_target_reg;
                            pc_stall        = 1'b0;
                            pend_valid_next = 1'b0;
                            state_next      = FETCH;
                        end else begin
                            // Delay slot parked; the target loads on HOLD release.
                            hold_buf_next = imem_rdata;
                            state_next    = HOLD;
                        end
                    end
                end

                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FETCH;
            hold_buf_reg    <= 32'h0;
            pend_valid_reg  <= 1'b0;
            pend_kill_reg   <= 1'b0;
            pend_target_reg <= 32'h0;
        end else begin
            state_reg       <= state_next;
            hold_buf_reg    <= hold_buf_next;
            pend_valid_reg  <= pend_valid_next;
            pend_kill_reg   <= pend_kill_next;
            pend_target_reg <= pend_target_next;
        end
    end

endmodule
